// File: rtl/dag_addr_gen_pkg.sv
// Shared encodings and default widths for the data address generator.
package dag_addr_gen_pkg;

    localparam int DMA_SIZE_DEF  = 16;
    localparam int DMD_SIZE_DEF  = 16;
    localparam int NREG_DEF      = 8;
    localparam int RSEL_SIZE_DEF = 3;

    typedef enum logic [1:0] {
        CLS_I = 2'b00,
        CLS_M = 2'b01,
        CLS_L = 2'b10,
        CLS_B = 2'b11
    } reg_cls_e;

endpackage

// File: rtl/dag_circ_wrap.sv
// Combinational next-index computation: wrap(I+M) into the circular buffer [B, B+L).
module dag_circ_wrap #(
    parameter int W = 16
) (
    input  logic [W-1:0] idx,
    input  logic [W-1:0] mod,
    input  logic [W-1:0] base,
    input  logic [W-1:0] len,
    output logic [W-1:0] nidx
);

    // Two guard bits keep a negative modify distinguishable from a large
    // positive sum when comparing against the buffer limits.
    logic signed [W+1:0] sum;
    logic signed [W+1:0] lim_lo;
    logic signed [W+1:0] lim_hi;
    logic signed [W+1:0] adj;

    always_comb begin
        sum    = $signed({2'b00, idx}) + $signed({{2{mod[W-1]}}, mod});
        lim_lo = $signed({2'b00, base});
        lim_hi = lim_lo + $signed({2'b00, len});
        adj    = sum;
        if (len != '0) begin
            if (sum >= lim_hi)
                adj = sum - $signed({2'b00, len});
            else if (sum < lim_lo)
                adj = sum + $signed({2'b00, len});
        end
        nidx = adj[W-1:0];
    end

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator with I/M/L/B banks, pre/post-modify and circular wrap.
// Optional DAG_BITREV_EN adds ps_dg_brev to bit-reverse the emitted address.
module dag_addr_gen
    import dag_addr_gen_pkg::*;
#(
    parameter int DMA_SIZE  = DMA_SIZE_DEF,
    parameter int DMD_SIZE  = DMD_SIZE_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int RSEL_SIZE = RSEL_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps_dg_en,
    input  logic                   ps_dg_pre,
    input  logic [RSEL_SIZE-1:0]   ps_dg_iadd,
    input  logic [RSEL_SIZE-1:0]   ps_dg_madd,
    input  logic                   ps_dg_wrt_en,
    input  logic                   ps_dg_rd_en,
    input  logic [RSEL_SIZE+1:0]   ps_dg_radd,
    input  logic [DMD_SIZE-1:0]    bc_dt,
`ifdef DAG_BITREV_EN
    input  logic                   ps_dg_brev,
`endif
    output logic [DMA_SIZE-1:0]    dg_dm_add,
    output logic [DMD_SIZE-1:0]    dg_bc_dt
);

    logic [DMA_SIZE-1:0] i_reg [NREG];
    logic [DMA_SIZE-1:0] m_reg [NREG];
    logic [DMA_SIZE-1:0] l_reg [NREG];
    logic [DMA_SIZE-1:0] b_reg [NREG];

    reg_cls_e            r_cls;
    logic [RSEL_SIZE-1:0] r_idx;
    logic [DMA_SIZE-1:0] cur_i;
    logic [DMA_SIZE-1:0] new_i;
    logic [DMA_SIZE-1:0] addr;
    logic [DMA_SIZE-1:0] addr_out;
    logic [DMA_SIZE-1:0] ld_val;
    logic [DMA_SIZE-1:0] rd_val;

    assign r_cls  = reg_cls_e'(ps_dg_radd[RSEL_SIZE+1:RSEL_SIZE]);
    assign r_idx  = ps_dg_radd[RSEL_SIZE-1:0];
    assign ld_val = DMA_SIZE'(bc_dt);
    assign cur_i  = i_reg[ps_dg_iadd];

    // L and B are paired with the index register, M is selected independently.
    dag_circ_wrap #(.W(DMA_SIZE)) u_wrap (
        .idx  (cur_i),
        .mod  (m_reg[ps_dg_madd]),
        .base (b_reg[ps_dg_iadd]),
        .len  (l_reg[ps_dg_iadd]),
        .nidx (new_i)
    );

    assign addr = ps_dg_pre ? new_i : cur_i;

`ifdef DAG_BITREV_EN
    always_comb begin
        addr_out = addr;
        if (ps_dg_brev)
            for (int k = 0; k < DMA_SIZE; k++)
                addr_out[k] = addr[DMA_SIZE-1-k];
    end
`else
    assign addr_out = addr;
`endif

    always_comb begin
        rd_val = '0;
        case (r_cls)
            CLS_I: rd_val = i_reg[r_idx];
            CLS_M: rd_val = m_reg[r_idx];
            CLS_L: rd_val = l_reg[r_idx];
            CLS_B: rd_val = b_reg[r_idx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                i_reg[k] <= '0;
                m_reg[k] <= '0;
                l_reg[k] <= '0;
                b_reg[k] <= '0;
            end
            dg_dm_add <= '0;
            dg_bc_dt  <= '0;
        end else begin
            if (ps_dg_en) begin
                dg_dm_add <= addr_out;
                if (!ps_dg_pre)
                    i_reg[ps_dg_iadd] <= new_i;
            end
            // Loads come after the post-modify write so a load to the same I wins.
            if (ps_dg_wrt_en) begin
                case (r_cls)
                    CLS_I: i_reg[r_idx] <= ld_val;
                    CLS_M: m_reg[r_idx] <= ld_val;
                    CLS_L: l_reg[r_idx] <= ld_val;
                    CLS_B: begin
                        b_reg[r_idx] <= ld_val;
                        i_reg[r_idx] <= ld_val;
                    end
                endcase
            end
            if (ps_dg_rd_en)
                dg_bc_dt <= DMD_SIZE'(rd_val);
        end
    end

endmodule
